// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, shares the imem read port between fetch and debug reads,
// and feeds IF/ID from a QDEPTH-entry prefetch queue. Issue to inst_valid is 2 edges; fetch issue is credit-gated on queue room.
module imem_fetch_ctrl #(
  parameter int          DEPTH_WORDS = 32,
  parameter int          QDEPTH      = 2,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        dbg_req,
  input  logic [31:0] dbg_addr,
  output logic        dbg_ack,
  output logic [31:0] dbg_data,
  output logic        fault
);

  localparam int          CW       = $clog2(QDEPTH + 1);
  localparam logic [31:0] PC_LIMIT = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_FETCH = 2'd1,
    SLOT_DEBUG = 2'd2
  } slot_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } q_ent_t;

  function automatic logic pc_bad(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc >= PC_LIMIT);
  endfunction

  slot_t         r_slot, w_slot_nxt;
  logic [31:0]   r_imem_addr, w_addr_nxt;
  logic [31:0]   r_fetch_pc, w_fetch_pc_nxt;
  logic          r_last_dbg, w_last_dbg_nxt;
  logic          r_dbg_bad, w_dbg_bad_nxt;
  logic          r_fault, w_fault_nxt;
  logic          r_dbg_ack;
  logic [31:0]   r_dbg_data;
  q_ent_t        r_q [QDEPTH];
  q_ent_t        w_q_shift [QDEPTH];
  q_ent_t        w_push_ent;
  logic [CW-1:0] r_cnt, w_cnt_after, w_wr_idx;
  logic          w_push, w_pop, w_fetch_elig, w_dbg_grant;

  assign imem_addr  = r_imem_addr;
  assign inst_valid = (r_cnt != '0);
  assign inst_data  = r_q[0].instr;
  assign inst_pc    = r_q[0].pc;
  assign dbg_ack    = r_dbg_ack;
  assign dbg_data   = r_dbg_data;
  assign fault      = r_fault;

  // A redirect kills both the in-flight fetch capture and any pop in the same cycle.
  always_comb begin
    w_push          = (r_slot == SLOT_FETCH) && !redirect_valid;
    w_pop           = inst_valid && inst_ready && !redirect_valid;
    w_push_ent.pc   = r_imem_addr;
    w_push_ent.instr = imem_instr;
    w_wr_idx        = r_cnt - CW'(w_pop);
    w_cnt_after     = redirect_valid ? '0 : (r_cnt + CW'(w_push) - CW'(w_pop));
    w_fetch_elig    = !r_fault && (w_cnt_after < CW'(QDEPTH));
    w_dbg_grant     = dbg_req && !r_dbg_ack && (r_slot != SLOT_DEBUG) &&
                      (!w_fetch_elig || !r_last_dbg);
    for (int i = 0; i < QDEPTH; i++) w_q_shift[i] = r_q[i];
    for (int i = 0; i < QDEPTH - 1; i++) w_q_shift[i] = r_q[i + 1];
  end

  always_comb begin
    w_slot_nxt     = SLOT_IDLE;
    w_addr_nxt     = r_imem_addr;
    w_fetch_pc_nxt = r_fetch_pc;
    w_last_dbg_nxt = r_last_dbg;
    w_dbg_bad_nxt  = r_dbg_bad;
    w_fault_nxt    = r_fault;
    if (redirect_valid) begin
      w_fetch_pc_nxt = redirect_pc;
      if (pc_bad(redirect_pc)) begin
        w_fault_nxt = 1'b1;
      end else begin
        w_fault_nxt    = 1'b0;
        w_slot_nxt     = SLOT_FETCH;
        w_addr_nxt     = redirect_pc;
        w_fetch_pc_nxt = redirect_pc + 32'd4;
      end
    end else if (w_dbg_grant) begin
      // A bad debug address still owns the slot but leaves the memory address alone.
      w_slot_nxt     = SLOT_DEBUG;
      w_last_dbg_nxt = 1'b1;
      w_dbg_bad_nxt  = pc_bad(dbg_addr);
      if (!pc_bad(dbg_addr)) w_addr_nxt = dbg_addr;
    end else if (w_fetch_elig) begin
      if (pc_bad(r_fetch_pc)) begin
        w_fault_nxt = 1'b1;
      end else begin
        w_slot_nxt     = SLOT_FETCH;
        w_addr_nxt     = r_fetch_pc;
        w_fetch_pc_nxt = r_fetch_pc + 32'd4;
        w_last_dbg_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slot      <= SLOT_IDLE;
      r_imem_addr <= RESET_PC;
      r_fetch_pc  <= RESET_PC;
      r_last_dbg  <= 1'b1;
      r_dbg_bad   <= 1'b0;
      r_fault     <= 1'b0;
      r_dbg_ack   <= 1'b0;
      r_dbg_data  <= '0;
      r_cnt       <= '0;
    end else begin
      r_slot      <= w_slot_nxt;
      r_imem_addr <= w_addr_nxt;
      r_fetch_pc  <= w_fetch_pc_nxt;
      r_last_dbg  <= w_last_dbg_nxt;
      r_dbg_bad   <= w_dbg_bad_nxt;
      r_fault     <= w_fault_nxt;
      r_cnt       <= w_cnt_after;
      r_dbg_ack   <= (r_slot == SLOT_DEBUG);
      if (r_slot == SLOT_DEBUG) r_dbg_data <= r_dbg_bad ? 32'h0 : imem_instr;
    end
  end

  // Shift-register queue: head is always entry 0; the push lands after any shift.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < QDEPTH; i++) r_q[i] <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (w_push && (CW'(i) == w_wr_idx)) r_q[i] <= w_push_ent;
        else if (w_pop) r_q[i] <= w_q_shift[i];
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: cycle-exact vector table, directed fault/debug sequences,
// then random traffic against a transaction-level program-order and debug-read scoreboard.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        reset_n;
  logic [31:0] imem_addr, imem_instr, inst_data, inst_pc, redirect_pc, dbg_addr, dbg_data;
  logic        inst_valid, inst_ready, redirect_valid, dbg_req, dbg_ack, fault;
  logic [31:0] mem [32];

  int n_total = 0;
  int n_bad   = 0;

  imem_fetch_ctrl #(.DEPTH_WORDS(32), .QDEPTH(2), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_data(dbg_data),
    .fault(fault)
  );

  assign imem_instr = mem[imem_addr[6:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit          rdy;
    bit          rv;
    logic [31:0] rpc;
    bit          dreq;
    logic [31:0] daddr;
    bit          e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_data;
    logic [31:0] e_addr;
    bit          e_ack;
    logic [31:0] e_ddata;
    bit          e_fault;
  } vec_t;

  function automatic vec_t mkv(bit rdy, bit rv, logic [31:0] rpc, bit dreq, logic [31:0] daddr,
                               bit ev, logic [31:0] epc, logic [31:0] edat, logic [31:0] eaddr,
                               bit eack, logic [31:0] eddata);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.dreq = dreq; v.daddr = daddr;
    v.e_valid = ev; v.e_pc = epc; v.e_data = edat; v.e_addr = eaddr;
    v.e_ack = eack; v.e_ddata = eddata; v.e_fault = 1'b0;
    return v;
  endfunction

  function automatic bit bad_pc(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc >= 32'h80);
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t        vt [22];
  logic [31:0] exp_pc, hold_addr, tgt, last_tgt, dbg_exp;
  int          npop, acks, n_pop, dbg_wait;
  bit          rdy, rv, last_rv, dbg_out;

  initial begin
    reset_n = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    dbg_req = 1'b0; dbg_addr = 32'h0;
    for (int i = 0; i < 32; i++) mem[i] = 32'(i);

    vt[0]  = mkv(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0,  32'h0,  32'h0,  1'b0, 32'h0);
    vt[1]  = mkv(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h0,  32'h0,  32'h4,  1'b0, 32'h0);
    vt[2]  = mkv(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h4,  32'h1,  32'h8,  1'b0, 32'h0);
    vt[3]  = mkv(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h8,  32'h2,  32'hC,  1'b0, 32'h0);
    for (int i = 4; i < 10; i++)
      vt[i] = mkv(1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'h8,  32'h2,  32'hC,  1'b0, 32'h0);
    vt[10] = mkv(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'hC,  32'h3,  32'h10, 1'b0, 32'h0);
    vt[11] = mkv(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h10, 32'h4,  32'h14, 1'b0, 32'h0);
    vt[12] = mkv(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h10, 32'h4,  32'h14, 1'b0, 32'h0);
    vt[13] = mkv(1'b1, 1'b1, 32'h40, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,  32'h40, 1'b0, 32'h0);
    vt[14] = mkv(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h40, 32'h10, 32'h44, 1'b0, 32'h0);
    vt[15] = mkv(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h44, 32'h11, 32'h48, 1'b0, 32'h0);
    vt[16] = mkv(1'b1, 1'b1, 32'h20, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,  32'h20, 1'b0, 32'h0);
    vt[17] = mkv(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h20, 32'h8,  32'h24, 1'b0, 32'h0);
    vt[18] = mkv(1'b1, 1'b0, 32'h0,  1'b1, 32'h1C, 1'b1, 32'h24, 32'h9,  32'h1C, 1'b0, 32'h0);
    vt[19] = mkv(1'b1, 1'b0, 32'h0,  1'b1, 32'h1C, 1'b0, 32'h0,  32'h0,  32'h28, 1'b1, 32'h7);
    vt[20] = mkv(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h28, 32'hA,  32'h2C, 1'b0, 32'h7);
    vt[21] = mkv(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h2C, 32'hB,  32'h30, 1'b0, 32'h7);

    #12 reset_n = 1'b1;
    #1;
    chk1("rst.valid", inst_valid, 1'b0);
    chk32("rst.addr", imem_addr, 32'h0);
    chk32("rst.pc", inst_pc, 32'h0);
    chk32("rst.data", inst_data, 32'h0);
    chk1("rst.ack", dbg_ack, 1'b0);
    chk1("rst.fault", fault, 1'b0);

    for (int k = 0; k < 22; k++) begin
      inst_ready = vt[k].rdy; redirect_valid = vt[k].rv; redirect_pc = vt[k].rpc;
      dbg_req = vt[k].dreq; dbg_addr = vt[k].daddr;
      step();
      chk1($sformatf("v%0d.valid", k), inst_valid, vt[k].e_valid);
      if (vt[k].e_valid) begin
        chk32($sformatf("v%0d.pc", k), inst_pc, vt[k].e_pc);
        chk32($sformatf("v%0d.data", k), inst_data, vt[k].e_data);
      end
      chk32($sformatf("v%0d.addr", k), imem_addr, vt[k].e_addr);
      chk1($sformatf("v%0d.ack", k), dbg_ack, vt[k].e_ack);
      chk32($sformatf("v%0d.dbg_data", k), dbg_data, vt[k].e_ddata);
      chk1($sformatf("v%0d.fault", k), fault, vt[k].e_fault);
    end
    redirect_valid = 1'b0; dbg_req = 1'b0;

    // Run off the end of memory: 0x70..0x7C drain, then fetch stops with fault.
    inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h70;
    step();
    redirect_valid = 1'b0;
    chk1("r70.valid", inst_valid, 1'b0);
    chk32("r70.addr", imem_addr, 32'h70);
    step(); step();
    chk32("stall.addr", imem_addr, 32'h74);
    chk32("stall.pc", inst_pc, 32'h70);
    inst_ready = 1'b1; exp_pc = 32'h70; npop = 0;
    for (int c = 0; c < 16; c++) begin
      if (inst_valid) begin
        chk32("runoff.pc", inst_pc, exp_pc);
        chk32("runoff.data", inst_data, exp_pc >> 2);
        exp_pc = exp_pc + 32'd4;
        npop++;
      end
      step();
    end
    chk32("runoff.npop", 32'(npop), 32'd4);
    chk1("runoff.fault", fault, 1'b1);
    chk1("runoff.valid", inst_valid, 1'b0);
    chk32("runoff.addr", imem_addr, 32'h7C);
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    step();
    redirect_valid = 1'b0;
    chk1("r10.fault", fault, 1'b0);
    chk1("r10.valid0", inst_valid, 1'b0);
    step();
    chk1("r10.valid1", inst_valid, 1'b1);
    chk32("r10.pc", inst_pc, 32'h10);
    chk32("r10.data", inst_data, 32'h4);

    // Misaligned redirect, then an out-of-range debug read.
    redirect_valid = 1'b1; redirect_pc = 32'h06;
    step();
    redirect_valid = 1'b0;
    chk1("r06.fault", fault, 1'b1);
    chk1("r06.valid", inst_valid, 1'b0);
    hold_addr = imem_addr;
    dbg_req = 1'b1; dbg_addr = 32'h200; acks = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (dbg_ack) begin
        acks++;
        chk32("dbg200.data", dbg_data, 32'h0);
        chk32("dbg200.addr", imem_addr, hold_addr);
        dbg_req = 1'b0;
      end
    end
    chk32("dbg200.acks", 32'(acks), 32'd1);
    chk1("dbg200.valid", inst_valid, 1'b0);
    chk1("dbg200.fault", fault, 1'b1);

    // Asynchronous reset mid-cycle, then random traffic.
    #3 reset_n = 1'b0;
    #1;
    chk1("arst.valid", inst_valid, 1'b0);
    chk32("arst.addr", imem_addr, 32'h0);
    chk1("arst.fault", fault, 1'b0);
    chk1("arst.ack", dbg_ack, 1'b0);
    chk32("arst.pc", inst_pc, 32'h0);
    inst_ready = 1'b0; redirect_valid = 1'b0; dbg_req = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    step(); step();
    #2 reset_n = 1'b1;

    exp_pc = 32'h0; last_rv = 1'b0; last_tgt = 32'h0; dbg_out = 1'b0; dbg_wait = 0; n_pop = 0;
    dbg_exp = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (last_rv) begin
        chk1("rnd.flush_valid", inst_valid, 1'b0);
        chk1("rnd.redir_fault", fault, bad_pc(last_tgt));
      end
      if (dbg_ack) begin
        chk1("rnd.ack_owed", dbg_out, 1'b1);
        chk32("rnd.dbg_data", dbg_data, dbg_exp);
        dbg_out = 1'b0; dbg_req = 1'b0;
      end else if (dbg_out) begin
        dbg_wait++;
        if (dbg_wait > 40) begin
          n_total++; n_bad++;
          $display("FAIL rnd.dbg_timeout: no ack after %0d cycles for addr %h", dbg_wait, dbg_addr);
          dbg_out = 1'b0; dbg_req = 1'b0;
        end
      end else if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 5))
          0:       dbg_addr = 32'($urandom_range(0, 31) << 2) | 32'($urandom_range(1, 3));
          1:       dbg_addr = 32'h80 + 32'($urandom_range(0, 127) << 2);
          default: dbg_addr = 32'($urandom_range(0, 31) << 2);
        endcase
        dbg_exp  = bad_pc(dbg_addr) ? 32'h0 : mem[dbg_addr[6:2]];
        dbg_req  = 1'b1; dbg_out = 1'b1; dbg_wait = 0;
      end

      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 7))
        0:       tgt = 32'($urandom_range(0, 31) << 2) | 32'($urandom_range(1, 3));
        1:       tgt = 32'h80 + 32'($urandom_range(0, 63) << 2);
        default: tgt = 32'($urandom_range(0, 31) << 2);
      endcase
      if (bad_pc(exp_pc)) begin
        chk1("rnd.dead_valid", inst_valid, 1'b0);
      end else if (inst_valid && rdy && !rv) begin
        chk32("rnd.pc", inst_pc, exp_pc);
        chk32("rnd.data", inst_data, mem[exp_pc[6:2]]);
        exp_pc = exp_pc + 32'd4;
        n_pop++;
      end
      if (rv) exp_pc = tgt;
      last_rv = rv; last_tgt = tgt;
      inst_ready = rdy; redirect_valid = rv; redirect_pc = tgt;
      step();
    end
    chk1("rnd.progress", (n_pop > 300), 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
